mac_sequencer: RTL and testbench

//  Sequences one multiply-accumulate job through the mult -> syncAccum -> accumulator path.

---
 rtl/mac_pkg.sv | 17 +
 rtl/mac_sequencer_valid_pipe.sv | 51 +++++
 rtl/mac_sequencer.sv | 142 ++++++++++++++
 tb/tb_mac_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate job sequencer.
// Default widths and pipe depth, plus the controller state encoding.
package mac_pkg;

   localparam int DEF_LEN_W    = 8;
   localparam int DEF_ACC_W    = 24;
   localparam int DEF_PIPE_LAT = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      DRAIN = 3'd2,
      CAPT  = 3'd3,
      DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/mac_sequencer_valid_pipe.sv
// Valid/first tracking pipe that shadows the multiplier pipeline.
// Each operand read pushes {valid, first}. The entry reaches the output stage
// exactly when its product arrives at the accumulator input.
// empty      : no entry anywhere in the pipe.
// empty_next : after the coming edge the pipe is empty (no push, and only the
//              output stage, if anything, is occupied).
module mac_valid_pipe #(
   parameter int PIPE_LAT = 4
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic push,
   input  logic push_first,
   output logic out_valid,
   output logic out_first,
   output logic empty,
   output logic empty_next
);

   logic [PIPE_LAT-1:0] vld;
   logic [PIPE_LAT-1:0] fst;

   // Shift register; cleared synchronously on reset or job cancel.
   always_ff @(posedge clock) begin
      if (!reset_n || clear) begin
         vld <= '0;
         fst <= '0;
      end else begin
         vld[0] <= push;
         fst[0] <= push & push_first;
         for (int i = 1; i < PIPE_LAT; i++) begin
            vld[i] <= vld[i-1];
            fst[i] <= fst[i-1];
         end
      end
   end

   assign out_valid = vld[PIPE_LAT-1];
   assign out_first = fst[PIPE_LAT-1];
   assign empty     = ~|vld;

   // Look-ahead empty: only the output stage may still hold an entry.
   always_comb begin
      empty_next = ~push;
      for (int i = 0; i < PIPE_LAT - 1; i++) begin
         if (vld[i]) empty_next = 1'b0;
      end
   end

endmodule

// File: rtl/mac_sequencer.sv
// Multiply-accumulate job sequencer: issues len operand reads, tracks the
// products through the multiplier pipe, drives accumulator load/add, then
// captures the 25-bit sum and pulses done.
// Optional build macro MAC_SAT_EN: saturate the captured result to all ones
// when the accumulator carry bit is set.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | one operand read per cycle, addresses 0..len-1
// DRAIN | reads finished, waiting for the last product to reach the accumulator
// CAPT  | accumulator holds the final sum; capture it
// DONE  | done pulse with result valid, then back to IDLE
module mac_sequencer
   import mac_pkg::*;
#(
   parameter int LEN_W    = DEF_LEN_W,
   parameter int ACC_W    = DEF_ACC_W,
   parameter int PIPE_LAT = DEF_PIPE_LAT
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   output logic             op_rd_en,
   output logic [LEN_W-1:0] op_addr,
   output logic             accum_load,
   output logic             accum_add,
   input  logic [ACC_W:0]   accum_output25,
   output logic [ACC_W:0]   result,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   state_t           state;
   logic [LEN_W-1:0] last_addr;
   logic             cancel;
   logic             pipe_valid;
   logic             pipe_first;
   logic             pipe_empty;
   logic             pipe_empty_next;

   // Abort only means something once a job is in flight.
   assign cancel = abort && (state != IDLE);

   mac_valid_pipe #(
      .PIPE_LAT (PIPE_LAT)
   ) u_valid_pipe (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear      (cancel),
      .push       (op_rd_en),
      .push_first (op_addr == '0),
      .out_valid  (pipe_valid),
      .out_first  (pipe_first),
      .empty      (pipe_empty),
      .empty_next (pipe_empty_next)
   );

   assign accum_load = pipe_valid & pipe_first;
   assign accum_add  = pipe_valid & ~pipe_first;

   // Job FSM with address counter and result capture.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         op_rd_en  <= 1'b0;
         op_addr   <= '0;
         last_addr <= '0;
         result    <= '0;
         ovf       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (cancel) begin
            state    <= IDLE;
            op_rd_en <= 1'b0;
            busy     <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (len != '0) begin
                        state     <= ISSUE;
                        op_rd_en  <= 1'b1;
                        op_addr   <= '0;
                        last_addr <= len - 1'b1;
                        busy      <= 1'b1;
                     end else begin
                        state  <= DONE;
                        result <= '0;
                        ovf    <= 1'b0;
                        done   <= 1'b1;
                     end
                  end
               end
               ISSUE: begin
                  if (op_addr == last_addr) begin
                     state    <= DRAIN;
                     op_rd_en <= 1'b0;
                  end else begin
                     op_addr <= op_addr + 1'b1;
                  end
               end
               DRAIN: begin
                  // The last accumulator enable is in flight this cycle; the
                  // accumulator output is final one cycle later in CAPT.
                  if (pipe_empty || pipe_empty_next) state <= CAPT;
               end
               CAPT: begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`ifdef MAC_SAT_EN
                  if (accum_output25[ACC_W]) begin
                     result <= '1;
                     ovf    <= 1'b1;
                  end else begin
                     result <= accum_output25;
                     ovf    <= 1'b0;
                  end
`else
                  result <= accum_output25;
                  ovf    <= accum_output25[ACC_W];
`endif
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state    <= IDLE;
                  op_rd_en <= 1'b0;
                  busy     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer. The bench plays the accumulator: it
// loads/adds the next queued product on each enable and presents the
// registered 24-bit sum with the carry in bit 24.
module tb_mac_sequencer;

   localparam int SPAN = 24;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  len = '0;
   logic        abort = 1'b0;
   logic        op_rd_en;
   logic [7:0]  op_addr;
   logic        accum_load;
   logic        accum_add;
   logic [24:0] accum_output25;
   logic [24:0] result;
   logic        ovf;
   logic        busy;
   logic        done;

   int checks = 0;
   int failures = 0;

   logic [23:0] prods [0:255];
   int          prod_idx = 0;
   logic [24:0] acc = '0;

   int rd_cnt, addr_err, load_cnt, add_cnt, both_cnt, load_cyc, last_en_cyc;
   int done_cyc, done_cnt;
   logic busy_c1, busy_post_abort, busy_after_done;
   logic [24:0] res_done;
   logic [25:0] exp_t3;

   always #5 clock = ~clock;

   mac_sequencer dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .start          (start),
      .len            (len),
      .abort          (abort),
      .op_rd_en       (op_rd_en),
      .op_addr        (op_addr),
      .accum_load     (accum_load),
      .accum_add      (accum_add),
      .accum_output25 (accum_output25),
      .result         (result),
      .ovf            (ovf),
      .busy           (busy),
      .done           (done)
   );

   // Accumulator stand-in: carry is not sticky, a load clears it.
   always @(posedge clock) begin
      if (accum_load === 1'b1) begin
         acc      <= {1'b0, prods[prod_idx]};
         prod_idx <= prod_idx + 1;
      end else if (accum_add === 1'b1) begin
         acc      <= {1'b0, acc[23:0]} + {1'b0, prods[prod_idx]};
         prod_idx <= prod_idx + 1;
      end
   end
   assign accum_output25 = acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic load_prods(input logic [23:0] p0, input logic [23:0] p1, input logic [23:0] p2);
      prods[prod_idx]     = p0;
      prods[prod_idx + 1] = p1;
      prods[prod_idx + 2] = p2;
   endtask

   // Start a job and observe SPAN cycles; cycle 1 is the first cycle after start is sampled.
   task automatic run_job(input logic [7:0] l, input int abort_cyc, input int extra_cyc,
                          input bit start_in_done);
      bit pend = 1'b0;
      rd_cnt = 0; addr_err = 0; load_cnt = 0; add_cnt = 0; both_cnt = 0;
      load_cyc = 0; last_en_cyc = 0; done_cyc = 0; done_cnt = 0;
      busy_c1 = 1'bx; busy_post_abort = 1'bx; busy_after_done = 1'bx; res_done = 'x;
      @(negedge clock);
      start = 1'b1;
      len   = l;
      for (int k = 1; k <= SPAN; k++) begin
         @(negedge clock);
         if (k == 1) begin
            start   = 1'b0;
            busy_c1 = busy;
         end
         if (op_rd_en === 1'b1) begin
            if (op_addr !== rd_cnt[7:0]) addr_err++;
            rd_cnt++;
         end
         if (accum_load === 1'b1) begin
            load_cnt++;
            if (load_cyc == 0) load_cyc = k;
            last_en_cyc = k;
         end
         if (accum_add === 1'b1) begin
            add_cnt++;
            last_en_cyc = k;
         end
         if (accum_load === 1'b1 && accum_add === 1'b1) both_cnt++;
         if (pend) begin
            busy_after_done = busy;
            start = 1'b0;
            pend  = 1'b0;
         end
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc == 0) begin
               done_cyc = k;
               res_done = result;
            end
            if (start_in_done) begin
               start = 1'b1;
               pend  = 1'b1;
            end
         end
         if (abort_cyc != 0 && k == abort_cyc + 1) begin
            abort = 1'b0;
            busy_post_abort = busy;
         end
         if (k == abort_cyc) abort = 1'b1;
         if (extra_cyc != 0 && k == extra_cyc) begin
            start = 1'b1;
            len   = 8'd9;
         end
         if (extra_cyc != 0 && k == extra_cyc + 1) start = 1'b0;
      end
   endtask

   initial begin
      // Reset
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_outputs", {7'd0, op_rd_en, op_addr, accum_load, accum_add, busy, done, ovf},
            32'd0);
      check("reset_result", {7'd0, result}, 32'd0);
      reset_n = 1'b1;

      // T1: len=3, 10+20+30
      load_prods(24'd10, 24'd20, 24'd30);
      run_job(8'd3, 0, 0, 1'b0);
      check("t1_busy_c1", {31'd0, busy_c1}, 32'd1);
      check("t1_reads", rd_cnt, 32'd3);
      check("t1_addr_seq", addr_err, 32'd0);
      check("t1_load_cyc", load_cyc, 32'd5);
      check("t1_load_cnt", load_cnt, 32'd1);
      check("t1_add_cnt", add_cnt, 32'd2);
      check("t1_last_en", last_en_cyc, 32'd7);
      check("t1_both", both_cnt, 32'd0);
      check("t1_done_cyc", done_cyc, 32'd9);
      check("t1_done_cnt", done_cnt, 32'd1);
      check("t1_result", {7'd0, res_done}, 32'd60);
      check("t1_ovf", {31'd0, ovf}, 32'd0);

      // T4: len=8, abort during 3rd ISSUE cycle
      load_prods(24'd1, 24'd1, 24'd1);
      run_job(8'd8, 3, 0, 1'b0);
      check("t4_busy_after_abort", {31'd0, busy_post_abort}, 32'd0);
      check("t4_reads", rd_cnt, 32'd3);
      check("t4_enables", load_cnt + add_cnt, 32'd0);
      check("t4_done_cnt", done_cnt, 32'd0);
      check("t4_result_kept", {7'd0, result}, 32'd60);
      check("t4_ovf_kept", {31'd0, ovf}, 32'd0);

      // T2: len=0
      run_job(8'd0, 0, 0, 1'b0);
      check("t2_reads", rd_cnt, 32'd0);
      check("t2_enables", load_cnt + add_cnt, 32'd0);
      check("t2_busy_c1", {31'd0, busy_c1}, 32'd0);
      check("t2_done_cyc", done_cyc, 32'd1);
      check("t2_done_cnt", done_cnt, 32'd1);
      check("t2_result", {7'd0, res_done}, 32'd0);

      // T3: carry out of the 24-bit sum
      load_prods(24'hFFFFFF, 24'd1, 24'd0);
      run_job(8'd2, 0, 0, 1'b0);
`ifdef MAC_SAT_EN
      exp_t3 = 26'h1FFFFFF;
`else
      exp_t3 = 26'h1000000;
`endif
      check("t3_load_cyc", load_cyc, 32'd5);
      check("t3_add_cnt", add_cnt, 32'd1);
      check("t3_done_cyc", done_cyc, 32'd8);
      check("t3_result", {7'd0, res_done}, {6'd0, exp_t3});
      check("t3_ovf", {31'd0, ovf}, 32'd1);

      // T5: start during ISSUE (with a different len) and during DONE is ignored
      load_prods(24'd1, 24'd2, 24'd3);
      run_job(8'd3, 0, 2, 1'b1);
      check("t5_reads", rd_cnt, 32'd3);
      check("t5_done_cyc", done_cyc, 32'd9);
      check("t5_done_cnt", done_cnt, 32'd1);
      check("t5_busy_after_done", {31'd0, busy_after_done}, 32'd0);
      check("t5_result", {7'd0, res_done}, 32'd6);
      check("t5_ovf", {31'd0, ovf}, 32'd0);
      load_prods(24'd5, 24'd6, 24'd0);
      run_job(8'd2, 0, 0, 1'b0);
      check("t5b_load_cyc", load_cyc, 32'd5);
      check("t5b_done_cyc", done_cyc, 32'd8);
      check("t5b_result", {7'd0, res_done}, 32'd11);

      // T6: reset during DRAIN, then a len=1 job
      load_prods(24'd100, 24'd200, 24'd300);
      @(negedge clock);
      start = 1'b1;
      len   = 8'd3;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         if (k == 1) start = 1'b0;
      end
      reset_n = 1'b0;
      @(negedge clock);
      check("t6_outputs_zero", {7'd0, op_rd_en, op_addr, accum_load, accum_add, busy, done, ovf},
            32'd0);
      check("t6_result_zero", {7'd0, result}, 32'd0);
      reset_n = 1'b1;
      load_prods(24'd7, 24'd0, 24'd0);
      run_job(8'd1, 0, 0, 1'b0);
      check("t6_reads", rd_cnt, 32'd1);
      check("t6_load_cyc", load_cyc, 32'd5);
      check("t6_add_cnt", add_cnt, 32'd0);
      check("t6_done_cyc", done_cyc, 32'd7);
      check("t6_result", {7'd0, res_done}, 32'd7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
